// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the core load/store port (C)
//   and a DMA/debug requester (D). Grants are combinational from the requests
//   and the arbiter state. The memory bus is muxed from the granted port.
//   Read data is captured at the end of the grant cycle and returned the
//   following cycle.
//
//   Arbitration: round robin, with an optional D burst lock. A lock is bounded
//   to MAX_LOCK consecutive D grants whenever C is waiting.
//
// Ports
//   clk, reset                    clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata     port C request
//   c_gnt, c_rvalid, c_rdata      port C grant (comb), read return (registered)
//   d_*                           same as port C, for port D
//   d_lock                        D burst lock request, sampled with d_req
//   mem_we/mem_addr/mem_wdata     memory bus, driven by the granted port
//   mem_rdata                     memory read data, combinational from mem_addr
//
// Optional build macro DMEM_ARB_PERF_EN
//   Adds perf_clr (in) and three 32-bit counters as outputs:
//   perf_c_grants, perf_d_grants and perf_conflicts.
//
// FSM states
//   state   | meaning
//   ST_RR   | round robin between C and D
//   ST_LOCK | D holds a burst lock; C waits until the lock count reaches MAX_LOCK

module dmem_arbiter #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   perf_c_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_conflicts
`endif
);

  typedef enum logic {ST_RR, ST_LOCK} state_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t     state_q;
  logic       last_d_q;   // 1: the most recent grant went to D
  logic [7:0] lock_cnt_q;
  logic       gnt_c;
  logic       gnt_d;

  // While locked, every grant goes to D, so last_d_q is already 1 when the
  // lock is released. The release cycle therefore arbitrates as plain round
  // robin with D as the last winner, and no special case is needed.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (state_q == ST_LOCK && d_req && d_lock) begin
      if (lock_cnt_q == LOCK_MAX && c_req) gnt_c = 1'b1;
      else                                 gnt_d = 1'b1;
    end else if (c_req && d_req) begin
      if (last_d_q) gnt_c = 1'b1;
      else          gnt_d = 1'b1;
    end else begin
      gnt_c = c_req;
      gnt_d = d_req;
    end
  end

  // The reset input is also used in this combinational path, so that grants
  // and the memory bus stay quiet for the whole time reset is held.
  assign c_gnt = gnt_c & reset;
  assign d_gnt = gnt_d & reset;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RR;
      last_d_q   <= 1'b1;
      lock_cnt_q <= 8'd0;
    end else begin
      if (c_gnt)      last_d_q <= 1'b0;
      else if (d_gnt) last_d_q <= 1'b1;

      case (state_q)
        ST_RR: begin
          if (d_gnt && d_lock) begin
            state_q    <= ST_LOCK;
            lock_cnt_q <= 8'd1;
          end
        end
        ST_LOCK: begin
          if (d_req && d_lock) begin
            if (c_gnt) begin
              state_q    <= ST_RR;
              lock_cnt_q <= 8'd0;
            end else if (lock_cnt_q != LOCK_MAX) begin
              lock_cnt_q <= lock_cnt_q + 8'd1;
            end
          end else begin
            // In the release cycle D cannot be granted with d_lock set, so
            // the lock cannot be taken again in this same cycle.
            state_q    <= ST_RR;
            lock_cnt_q <= 8'd0;
          end
        end
        default: begin
          state_q    <= ST_RR;
          lock_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      d_rvalid <= d_gnt & ~d_we;
      if (c_gnt && !c_we) c_rdata <= mem_rdata;
      if (d_gnt && !d_we) d_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_c_grants  <= 32'd0;
      perf_d_grants  <= 32'd0;
      perf_conflicts <= 32'd0;
    end else if (perf_clr) begin
      perf_c_grants  <= 32'd0;
      perf_d_grants  <= 32'd0;
      perf_conflicts <= 32'd0;
    end else begin
      if (c_gnt)          perf_c_grants  <= perf_c_grants + 32'd1;
      if (d_gnt)          perf_d_grants  <= perf_d_grants + 32'd1;
      if (c_req && d_req) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [29:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_c_grants, perf_d_grants, perf_conflicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_lock    (d_lock),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_c_grants  (perf_c_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  // Memory model: unwritten words read back as 0x1000_0000 + index.
  logic [31:0] mem [0:63];
  logic [63:0] mem_vld = '0;

  assign mem_rdata = mem_vld[mem_addr[5:0]] ? mem[mem_addr[5:0]]
                                            : 32'h1000_0000 + {26'd0, mem_addr[5:0]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:0]]     <= mem_wdata;
      mem_vld[mem_addr[5:0]] <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 30'd1; c_wdata = 32'h1111_1111;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'd2; d_wdata = 32'h2222_2222;
    d_lock = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset held with both ports requesting writes
    repeat (2) next_cycle();
    #1;
    check_val("rst_c_gnt",    {31'd0, c_gnt},    32'd0);
    check_val("rst_d_gnt",    {31'd0, d_gnt},    32'd0);
    check_val("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check_val("rst_mem_addr", {2'd0, mem_addr},  32'd0);
    check_val("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
    check_val("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check_val("rst_c_rdata",  c_rdata,           32'd0);

    // Release reset into a read conflict: C, D, C, D
    next_cycle();
    reset = 1'b1; c_we = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      #1;
      check_val("rr_c_gnt", {31'd0, c_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val("rr_d_gnt", {31'd0, d_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check_val("rr_addr",  {2'd0, mem_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) begin
        check_val("rr_c_rvalid", {31'd0, c_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        check_val("rr_d_rvalid", {31'd0, d_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
        if (i % 2 == 1) check_val("rr_c_rdata", c_rdata, 32'h1000_0001);
        else            check_val("rr_d_rdata", d_rdata, 32'h1000_0002);
      end
    end
    next_cycle();
    c_req = 1'b0; d_req = 1'b0;
    #1;
    check_val("rr_last_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_val("rr_last_d_rdata",  d_rdata,           32'h1000_0002);
    check_val("rr_last_c_rvalid", {31'd0, c_rvalid}, 32'd0);

    // C writes 0x10, D reads it back the next cycle
    next_cycle();
    c_req = 1'b1; c_we = 1'b1; c_addr = 30'h10; c_wdata = 32'hDEAD_BEEF;
    #1;
    check_val("wr_c_gnt",  {31'd0, c_gnt},  32'd1);
    check_val("wr_mem_we", {31'd0, mem_we}, 32'd1);
    check_val("wr_addr",   {2'd0, mem_addr}, 32'h10);
    check_val("wr_wdata",  mem_wdata,       32'hDEAD_BEEF);
    next_cycle();
    c_req = 1'b0; c_we = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h10;
    #1;
    check_val("rd_d_gnt",   {31'd0, d_gnt},    32'd1);
    check_val("rd_mem_we",  {31'd0, mem_we},   32'd0);
    check_val("wr_no_rvld", {31'd0, c_rvalid}, 32'd0);
    next_cycle();
    d_req = 1'b0;
    #1;
    check_val("rd_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_val("rd_d_rdata",  d_rdata,           32'hDEAD_BEEF);
    check_val("rd_c_hold",   c_rdata,           32'h1000_0001);

    // Lock bound: C, then 8 locked D grants, C, then D locks again
    next_cycle();
    c_req = 1'b1; c_addr = 30'd3;
    d_req = 1'b1; d_lock = 1'b1; d_addr = 30'd4;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      #1;
      check_val("lk_c_gnt", {31'd0, c_gnt}, (i == 0 || i == 9) ? 32'd1 : 32'd0);
      check_val("lk_d_gnt", {31'd0, d_gnt}, (i == 0 || i == 9) ? 32'd0 : 32'd1);
      check_val("lk_both",  {31'd0, c_gnt & d_gnt}, 32'd0);
    end
    next_cycle();
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    #1;
    check_val("lk_idle_gnt", {30'd0, c_gnt, d_gnt}, 32'd0);
    check_val("lk_d_rvalid", {31'd0, d_rvalid},     32'd1);
    check_val("lk_d_rdata",  d_rdata,               32'h1000_0004);

    // Lock release: three locked D grants, then d_lock drops while C waits
    next_cycle();
    d_req = 1'b1; d_lock = 1'b1;
    #1;
    check_val("rel_d_gnt0", {31'd0, d_gnt}, 32'd1);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      c_req = 1'b1;
      #1;
      check_val("rel_d_gnt", {31'd0, d_gnt}, 32'd1);
      check_val("rel_c_gnt", {31'd0, c_gnt}, 32'd0);
    end
    next_cycle();
    d_lock = 1'b0;
    #1;
    check_val("rel_drop_c_gnt", {31'd0, c_gnt}, 32'd1);
    check_val("rel_drop_d_gnt", {31'd0, d_gnt}, 32'd0);
    next_cycle();
    #1;
    check_val("rel_rr_d_gnt", {31'd0, d_gnt}, 32'd1);
    next_cycle();
    c_req = 1'b0; d_req = 1'b0;

    // Saturation: 10 locked D grants with C idle; C is served on its first request
    next_cycle();
    d_req = 1'b1; d_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cycle();
      #1;
      check_val("sat_d_gnt", {31'd0, d_gnt}, 32'd1);
    end
    next_cycle();
    c_req = 1'b1;
    #1;
    check_val("sat_c_gnt", {31'd0, c_gnt}, 32'd1);
    check_val("sat_d_gnt_off", {31'd0, d_gnt}, 32'd0);
    next_cycle();
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;

    // Mid-operation reset: D read granted while taking a lock, reset on the next cycle
    next_cycle();
    d_req = 1'b1; d_lock = 1'b1; d_addr = 30'd5;
    #1;
    check_val("mid_d_gnt", {31'd0, d_gnt}, 32'd1);
    next_cycle();
    reset = 1'b0;
    #1;
    check_val("mid_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check_val("mid_d_rdata",  d_rdata,           32'd0);
    check_val("mid_d_gnt_rst", {31'd0, d_gnt},   32'd0);
    next_cycle();
    reset = 1'b1; c_req = 1'b1; c_addr = 30'd6;
    #1;
    check_val("mid_rr_c_gnt", {31'd0, c_gnt}, 32'd1);
    check_val("mid_rr_d_gnt", {31'd0, d_gnt}, 32'd0);
    next_cycle();
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    #1;
    check_val("mid_c_rvalid", {31'd0, c_rvalid}, 32'd1);
    check_val("mid_c_rdata",  c_rdata,           32'h1000_0006);

`ifdef DMEM_ARB_PERF_EN
    next_cycle();
    perf_clr = 1'b1;
    next_cycle();
    perf_clr = 1'b0; c_req = 1'b1; d_req = 1'b1;
    repeat (4) next_cycle();
    next_cycle();
    c_req = 1'b0; d_req = 1'b0;
    #1;
    check_val("perf_conflicts", perf_conflicts, 32'd5);
    check_val("perf_grant_sum", perf_c_grants + perf_d_grants, 32'd5);
    next_cycle();
    perf_clr = 1'b1; c_req = 1'b1;
    #1;
    check_val("perf_clr_c_gnt", {31'd0, c_gnt}, 32'd1);
    next_cycle();
    perf_clr = 1'b0; c_req = 1'b0;
    #1;
    check_val("perf_clr_c_grants", perf_c_grants,  32'd0);
    check_val("perf_clr_conflict", perf_conflicts, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
